// File: rtl/conv_bias_bank.sv
// Per-channel bias store for the convolution output stage: burst-loaded register
// bank with one-cycle registered readout in sequential or addressed order.
module conv_bias_bank #(
  parameter int BIAS_WIDTH = 32,
  parameter int NUM_CH     = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load_en,
  input  logic [BIAS_WIDTH-1:0] load_data,
  input  logic                  read_en,
  input  logic                  read_mode,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [BIAS_WIDTH-1:0] bias,
  output logic                  valid,
  output logic                  last,
  output logic                  rd_err,
  output logic                  load_done,
  output logic                  loaded
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_CH - 1);
  localparam logic [ADDR_WIDTH:0]   NUM_CH_X = (ADDR_WIDTH + 1)'(NUM_CH);

  logic signed [BIAS_WIDTH-1:0] mem_q [NUM_CH];
  logic signed [BIAS_WIDTH-1:0] mem_d [NUM_CH];
  logic [ADDR_WIDTH-1:0]        wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0]        rptr_q, rptr_d;
  logic                         loaded_q, loaded_d;
  logic                         load_done_q, load_done_d;
  logic signed [BIAS_WIDTH-1:0] bias_q, bias_d;
  logic                         valid_q, valid_d;
  logic                         last_q, last_d;
  logic                         rd_err_q, rd_err_d;

  logic                         addr_ok;
  logic [ADDR_WIDTH-1:0]        rd_idx;
  logic [ADDR_WIDTH-1:0]        wr_idx;
  logic signed [BIAS_WIDTH-1:0] rd_word;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_IDX) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  always_comb begin
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    loaded_d    = loaded_q;
    load_done_d = 1'b0;
    bias_d      = bias_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    rd_err_d    = 1'b0;

    addr_ok = ({1'b0, read_addr} < NUM_CH_X);
    rd_idx  = read_mode ? read_addr : rptr_q;
    // a fresh burst after a complete one always restarts at slot 0
    wr_idx  = loaded_q ? '0 : wptr_q;

    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_idx == ADDR_WIDTH'(i)) rd_word = mem_q[i];
    end

    if (clear) begin
      wptr_d   = '0;
      rptr_d   = '0;
      loaded_d = 1'b0;
    end else begin
      // read side sees memory and loaded from before this edge
      if (read_en) begin
        if (loaded_q && (!read_mode || addr_ok)) begin
          bias_d  = rd_word;
          valid_d = 1'b1;
          if (!read_mode) begin
            last_d = (rptr_q == LAST_IDX);
            rptr_d = ptr_inc(rptr_q);
          end
        end else begin
          rd_err_d = 1'b1;
        end
      end

      if (load_en) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_idx == ADDR_WIDTH'(i)) mem_d[i] = load_data;
        end
        if (wr_idx == LAST_IDX) begin
          wptr_d      = '0;
          loaded_d    = 1'b1;
          load_done_d = 1'b1;
        end else begin
          wptr_d   = wr_idx + ADDR_WIDTH'(1);
          loaded_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) mem_q[i] <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      loaded_q    <= 1'b0;
      load_done_q <= 1'b0;
      bias_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      loaded_q    <= loaded_d;
      load_done_q <= load_done_d;
      bias_q      <= bias_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign bias      = bias_q;
  assign valid     = valid_q;
  assign last      = last_q;
  assign rd_err    = rd_err_q;
  assign load_done = load_done_q;
  assign loaded    = loaded_q;

endmodule

// File: doc/conv_bias_bank.md
# conv_bias_bank

Multi-channel bias store for the convolution output stage. It holds one bias word per output channel. Biases are loaded as a burst of NUM_CH words and read back one per cycle, either in sequential channel order or by channel address. The block replaces the single-word bias holder and sits between the parameter loader and the per-channel accumulator/adder. It reports load completion, a per-pass wrap marker and illegal read attempts.

## Interface
Parameters:
- BIAS_WIDTH, 32, width of one bias word (signed two's complement, passed through unmodified)
- NUM_CH, 16, number of output channels stored; legal range is 2 or more
- ADDR_WIDTH, 4, channel index width; must satisfy 2^ADDR_WIDTH ≥ NUM_CH

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous restart: zeroes pointers and `loaded`; memory contents are kept
- load_en  in  1  write load_data into the next channel slot this cycle
- load_data  in  BIAS_WIDTH  bias word to be written
- read_en  in  1  read request
- read_mode  in  1  0 = sequential (internal pointer), 1 = addressed (read_addr)
- read_addr  in  ADDR_WIDTH  channel index; used only when read_mode=1
- bias  out  BIAS_WIDTH  registered bias output
- valid  out  1  bias is valid this cycle
- last  out  1  high together with valid when channel NUM_CH-1 is returned in sequential mode
- rd_err  out  1  one-cycle pulse when a read request is rejected
- load_done  out  1  one-cycle pulse after the NUM_CH-th word of a burst is written
- loaded  out  1  level signal: the bank holds a complete burst

## Operation
- Storage: register array mem[0..NUM_CH-1], write pointer wptr, sequential read pointer rptr.
- Load:
  - Each load_en cycle writes mem[wptr] ← load_data and increments wptr.
  - On the write at wptr = NUM_CH-1: wptr wraps to 0, `loaded` goes to 1 and `load_done` pulses on the next cycle.
  - A load_en while loaded=1 starts a new burst: the write goes to slot 0 and `loaded` clears on the same edge.
  - A partial burst leaves loaded=0.
- Read acceptance: a read is accepted when read_en=1, loaded=1 (value before the edge), and, in addressed mode, read_addr < NUM_CH.
- Accepted read:
  - bias ← mem[index] and valid=1 on the next cycle.
  - Sequential mode: index = rptr, then rptr increments and wraps from NUM_CH-1 to 0. `last`=1 when index = NUM_CH-1.
  - Addressed mode: index = read_addr. rptr is unchanged and last=0.
- Rejected read (loaded=0, or read_addr ≥ NUM_CH): valid=0, rd_err pulses for one cycle, and bias holds its previous value.
- No read request: valid, last and rd_err are 0; bias holds.
- Simultaneous load_en and read_en: the read returns the memory contents from before the edge (read-before-write). The read is evaluated against `loaded` from before the edge.
- clear:
  - Has priority over load_en and read_en in the same cycle.
  - Sets wptr=0, rptr=0, loaded=0, and valid/last/rd_err/load_done=0 on the next cycle.
  - bias and memory are not changed.

## Timing
- Reset values: bias=0, valid=0, last=0, rd_err=0, load_done=0, loaded=0, all mem words 0, wptr=0, rptr=0.
- Read latency is 1 cycle from the request edge to bias/valid. Throughput is one read per cycle with no bubbles, including across the wrap.
- load_done appears 1 cycle after the final write edge; `loaded` rises on that same edge. A read requested in the cycle load_done is high is accepted.
- Asserting rst mid-burst or mid-read-pass returns everything to reset values immediately. Outputs are never left partially updated.
- valid, last, rd_err and load_done are pulse-per-request signals; none of them is sticky.

## Test plan
- Reset and load: NUM_CH=16, load the values 100..115 on consecutive cycles → load_done pulses exactly once, 1 cycle after the 16th write; loaded=1 from that same edge.
- Sequential pass with wrap: 20 back-to-back reads in sequential mode → bias sequence 100..115, then 100..103; valid is high continuously; last=1 only on the outputs with value 115.
- Addressed mode: read_addr=7, then 0, then 15 → outputs 107, 100, 115. Then read_addr=16 with ADDR_WIDTH=5 → rd_err pulses, valid=0, and bias stays 115.
- Read before load: read_en asserted after reset → rd_err=1, valid=0. Then load 3 of 16 words and read → still rejected, loaded=0.
- Reload collision: with loaded=1, assert load_en(0xDEAD) and a sequential read of slot 0 in the same cycle → the read returns 100, loaded drops to 0, and a read on the next cycle is rejected.
- clear and async reset: clear mid-burst (after 5 writes), then a 16-word burst → all 16 words land in slots 0..15. rst asserted mid-pass → all outputs are 0 in the same cycle.
